sparse_chunk_encoder: RTL

SPARSE_CHUNK_ENCODER -- requirements
Module: sparse_chunk_encoder

---
 rtl/sparse_chunk_encoder.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/sparse_chunk_encoder.sv
// ---------------------------------------------------------------------------
// sparse_chunk_encoder
//
// Collects one chunk of MEM_SIZE bytes arriving as BEAT_NUM dense beats of
// BUS_SIZE bytes. For every accepted beat it records a sparsemap (one bit per
// byte, set when the byte is nonzero) and appends the nonzero bytes, in
// ascending channel order, to a packed buffer. Once the chunk is complete and
// the downstream write buffer is free (out_en_i), the map and packed buffer
// are written out as BEAT_NUM registered beats, followed by a one-cycle
// chunk_done_o pulse and a ping-pong buffer select toggle.
//
// Optional feature: define ENCODER_ZERO_PAD_EN to let dense_last_i end a
// chunk early. Beats that were never received stay zero in both the map and
// the packed buffer, and all BEAT_NUM beats are still emitted. Without the
// macro, dense_last_i is ignored.
//
// Ports
//   clk_i          clock, all logic on the rising edge
//   rst_i          synchronous active-high reset
//   dense_dat_i    dense input beat, byte 0 = lowest channel
//   dense_valid_i  input beat valid
//   dense_last_i   final input beat of a chunk (ENCODER_ZERO_PAD_EN only)
//   dense_ready_o  high while collecting
//   out_en_i       downstream write buffer free, permits emission
//   nonzero_data_o packed nonzero-data slice of the current write beat
//   sparsemap_o    sparsemap slice of the current write beat
//   wr_valid_o     write beat valid
//   wr_count_o     write beat index
//   wr_sel_o       ping-pong write buffer select
//   nnz_cnt_o      nonzero byte count of the last collected chunk
//   chunk_done_o   one-cycle pulse after the final emitted beat
// ---------------------------------------------------------------------------
`ifndef BUS_SIZE
`define BUS_SIZE 4
`endif
`ifndef MEM_SIZE
`define MEM_SIZE 16
`endif

module sparse_chunk_encoder #(
  parameter int  BUS_SIZE = `BUS_SIZE,
  parameter int  MEM_SIZE = `MEM_SIZE,
  localparam int BEAT_NUM = MEM_SIZE / BUS_SIZE,
  localparam int CNT_W    = (BEAT_NUM > 1) ? $clog2(BEAT_NUM) : 1,
  localparam int PTR_W    = $clog2(MEM_SIZE) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [BUS_SIZE*8-1:0] dense_dat_i,
  input  logic                  dense_valid_i,
  input  logic                  dense_last_i,
  output logic                  dense_ready_o,
  input  logic                  out_en_i,
  output logic [BUS_SIZE*8-1:0] nonzero_data_o,
  output logic [BUS_SIZE-1:0]   sparsemap_o,
  output logic                  wr_valid_o,
  output logic [CNT_W-1:0]      wr_count_o,
  output logic                  wr_sel_o,
  output logic [PTR_W-1:0]      nnz_cnt_o,
  output logic                  chunk_done_o
);

  localparam int IDX_W  = $clog2(MEM_SIZE);
  localparam int BIDX_W = (BUS_SIZE > 1) ? $clog2(BUS_SIZE) : 1;

  typedef enum logic [1:0] {S_COLLECT, S_WAIT, S_EMIT} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [MEM_SIZE-1:0]   r_map;
  logic [7:0]            r_buf [MEM_SIZE];
  logic [CNT_W-1:0]      r_beat_cnt;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_nnz;
  logic                  r_wr_valid;
  logic [CNT_W-1:0]      r_wr_count;
  logic                  r_wr_sel;
  logic                  r_done;
  logic [BUS_SIZE*8-1:0] r_nz_dat;
  logic [BUS_SIZE-1:0]   r_smap;

  logic                  w_accept;
  logic                  w_last_beat;
  logic                  w_emit_last;
  logic [BUS_SIZE-1:0]   w_beat_map;
  logic [7:0]            w_comp [BUS_SIZE];
  logic [PTR_W-1:0]      w_pop;
  logic [CNT_W-1:0]      w_sel_idx;
  logic [BUS_SIZE-1:0]   w_slice_map;
  logic [BUS_SIZE*8-1:0] w_slice_dat;

`ifdef ENCODER_ZERO_PAD_EN
  assign w_last_beat = (r_beat_cnt == CNT_W'(BEAT_NUM - 1)) || dense_last_i;
`else
  logic w_unused_last;
  assign w_unused_last = dense_last_i;
  assign w_last_beat   = (r_beat_cnt == CNT_W'(BEAT_NUM - 1));
`endif

  assign w_accept    = dense_valid_i && dense_ready_o;
  // The beat currently on the write port is the last one of the chunk.
  assign w_emit_last = (r_wr_count == CNT_W'(BEAT_NUM - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_COLLECT;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    dense_ready_o = 1'b0;
    case (r_state)
      S_COLLECT: begin
        dense_ready_o = 1'b1;
        if (w_accept && w_last_beat) w_next = S_WAIT;
      end
      S_WAIT:  if (out_en_i)    w_next = S_EMIT;
      S_EMIT:  if (w_emit_last) w_next = S_COLLECT;
      default: w_next = S_COLLECT;
    endcase
  end

  // Beat map and left-compaction of the nonzero bytes of the input beat.
  always_comb begin
    int k;
    k = 0;
    for (int i = 0; i < BUS_SIZE; i++) w_comp[i] = 8'd0;
    for (int i = 0; i < BUS_SIZE; i++) begin
      w_beat_map[i] = (dense_dat_i[i*8 +: 8] != 8'd0);
      if (w_beat_map[i]) begin
        w_comp[BIDX_W'(k)] = dense_dat_i[i*8 +: 8];
        k = k + 1;
      end
    end
    w_pop = PTR_W'(k);
  end

  // Slice for the next write beat: beat 0 when leaving WAIT, else count+1.
  always_comb begin
    w_sel_idx   = (r_state == S_EMIT) ? r_wr_count + CNT_W'(1) : '0;
    w_slice_map = '0;
    w_slice_dat = '0;
    for (int b = 0; b < BEAT_NUM; b++) begin
      if (w_sel_idx == CNT_W'(b)) begin
        w_slice_map = r_map[b*BUS_SIZE +: BUS_SIZE];
        for (int j = 0; j < BUS_SIZE; j++) w_slice_dat[j*8 +: 8] = r_buf[b*BUS_SIZE + j];
      end
    end
  end

  // Collection storage and registered write port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_map      <= '0;
      for (int s = 0; s < MEM_SIZE; s++) r_buf[s] <= 8'd0;
      r_beat_cnt <= '0;
      r_wr_ptr   <= '0;
      r_nnz      <= '0;
      r_wr_valid <= 1'b0;
      r_wr_count <= '0;
      r_wr_sel   <= 1'b0;
      r_done     <= 1'b0;
      r_nz_dat   <= '0;
      r_smap     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_COLLECT: begin
          if (w_accept) begin
            for (int b = 0; b < BEAT_NUM; b++)
              if (r_beat_cnt == CNT_W'(b)) r_map[b*BUS_SIZE +: BUS_SIZE] <= w_beat_map;
            // Append compacted bytes at the write pointer; never past the end.
            for (int j = 0; j < BUS_SIZE; j++)
              if ((PTR_W'(j) < w_pop) && (int'(r_wr_ptr) + j < MEM_SIZE))
                r_buf[IDX_W'(int'(r_wr_ptr) + j)] <= w_comp[j];
            r_wr_ptr <= r_wr_ptr + w_pop;
            if (w_last_beat) begin
              r_beat_cnt <= '0;
              r_nnz      <= r_wr_ptr + w_pop;
            end else begin
              r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
          end
        end
        S_WAIT: begin
          if (out_en_i) begin
            r_wr_valid <= 1'b1;
            r_wr_count <= '0;
            r_smap     <= w_slice_map;
            r_nz_dat   <= w_slice_dat;
          end
        end
        S_EMIT: begin
          if (w_emit_last) begin
            r_wr_valid <= 1'b0;
            r_wr_count <= '0;
            r_smap     <= '0;
            r_nz_dat   <= '0;
            r_done     <= 1'b1;
            r_wr_sel   <= ~r_wr_sel;
            // Returning to COLLECT: start the next chunk from a clean slate.
            r_map      <= '0;
            for (int s = 0; s < MEM_SIZE; s++) r_buf[s] <= 8'd0;
            r_beat_cnt <= '0;
            r_wr_ptr   <= '0;
          end else begin
            r_wr_count <= r_wr_count + CNT_W'(1);
            r_smap     <= w_slice_map;
            r_nz_dat   <= w_slice_dat;
          end
        end
        default: ;
      endcase
    end
  end

  assign nonzero_data_o = r_nz_dat;
  assign sparsemap_o    = r_smap;
  assign wr_valid_o     = r_wr_valid;
  assign wr_count_o     = r_wr_count;
  assign wr_sel_o       = r_wr_sel;
  assign nnz_cnt_o      = r_nnz;
  assign chunk_done_o   = r_done;

endmodule
